// File: rtl/fsgnj_pipe_pkg.sv
// Shared FPU definitions for the sign-injection unit: op and format
// encodings, single-precision NaN-boxing constants and the sign rule.
package fsgnj_pipe_pkg;

   typedef enum logic [1:0] {
      SGNJ  = 2'b00,
      SGNJN = 2'b01,
      SGNJX = 2'b10,
      RSVD  = 2'b11
   } sgnj_op_t;

   typedef enum logic {
      FMT_S = 1'b0,
      FMT_D = 1'b1
   } fmt_t;

   localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
   localparam logic [31:0] NANBOX_HI   = 32'hFFFF_FFFF;

   // Sign of the result given the op and both operand signs.
   // The reserved op keeps the magnitude source sign so x1 passes unchanged.
   function automatic logic inject_sign(input sgnj_op_t op, input logic s1, input logic s2);
      logic s;
      case (op)
         SGNJ:    s = s2;
         SGNJN:   s = ~s2;
         SGNJX:   s = s1 ^ s2;
         default: s = s1;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/fsgnj_pipe_core.sv
// Combinational sign-injection datapath: op/fmt -> result and illegal flag.
// With FLEN=64 and single format, operands that are not NaN-boxed are
// replaced by the canonical single NaN, and the result is re-boxed.
module fsgnj_core
   import fsgnj_pipe_pkg::*;
#(
   parameter int FLEN = 32
) (
   input  logic [1:0]      op,
   input  logic            fmt,
   input  logic [FLEN-1:0] x1,
   input  logic [FLEN-1:0] x2,
   output logic [FLEN-1:0] y,
   output logic            illegal
);

   sgnj_op_t    op_e;
   logic        boxed_mode;
   logic [63:0] a_w;
   logic [63:0] b_w;
   logic [31:0] a_s;
   logic        b_sign_s;
   logic        unused_b;

   // The magnitude bits of the sign source never reach the result.
   assign unused_b = ^b_w[30:0];

   // Select single (boxed) or full-width sign handling and build the result.
   always_comb begin
      op_e       = sgnj_op_t'(op);
      boxed_mode = (FLEN == 64) && (fmt_t'(fmt) == FMT_S);
      a_w        = 64'(x1);
      b_w        = 64'(x2);
      a_s        = (a_w[63:32] == NANBOX_HI) ? a_w[31:0] : CANON_NAN_S;
      b_sign_s   = (b_w[63:32] == NANBOX_HI) ? b_w[31] : CANON_NAN_S[31];
      y          = x1;
      illegal    = 1'b0;
      if (op_e == RSVD) begin
         illegal = 1'b1;
      end else if (boxed_mode) begin
         y = FLEN'({NANBOX_HI, inject_sign(op_e, a_s[31], b_sign_s), a_s[30:0]});
      end else begin
         y[FLEN-1] = inject_sign(op_e, x1[FLEN-1], x2[FLEN-1]);
      end
   end

endmodule

// File: rtl/fsgnj_pipe.sv
// Pipelined FSGNJ/FSGNJN/FSGNJX unit with an elastic valid/ready chain.
// The result is computed ahead of stage 0; later stages only buffer it,
// so capacity equals STAGES and latency is STAGES cycles without stalls.
// FLEN must be 32 or 64 and STAGES at least 1.
module fsgnj_pipe
   import fsgnj_pipe_pkg::*;
#(
   parameter int FLEN   = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic             fmt,
   input  logic [FLEN-1:0]  x1,
   input  logic [FLEN-1:0]  x2,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FLEN-1:0]  y,
   output logic [TAG_W-1:0] tag_out,
   output logic             illegal
);

   logic [FLEN-1:0]  core_y;
   logic             core_ill;

   logic             v_q   [STAGES];
   logic             v_d   [STAGES];
   logic [FLEN-1:0]  y_q   [STAGES];
   logic [FLEN-1:0]  y_d   [STAGES];
   logic [TAG_W-1:0] tag_q [STAGES];
   logic [TAG_W-1:0] tag_d [STAGES];
   logic             ill_q [STAGES];
   logic             ill_d [STAGES];
   logic             load  [STAGES];

   fsgnj_core #(.FLEN(FLEN)) u_core (
      .op      (op),
      .fmt     (fmt),
      .x1      (x1),
      .x2      (x2),
      .y       (core_y),
      .illegal (core_ill)
   );

   // Ready ripples back from the consumer: a stage can load when it is
   // empty or its contents are leaving this cycle.
   always_comb begin
      logic down_ready;
      down_ready = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         load[k]    = !v_q[k] || down_ready;
         down_ready = load[k];
      end
   end

   assign in_ready = load[0];

   // Next state of every stage: hold, or take the upstream contents.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         v_d[k]   = v_q[k];
         y_d[k]   = y_q[k];
         tag_d[k] = tag_q[k];
         ill_d[k] = ill_q[k];
      end
      if (load[0]) begin
         v_d[0] = in_valid;
         if (in_valid) begin
            y_d[0]   = core_y;
            tag_d[0] = tag_in;
            ill_d[0] = core_ill;
         end
      end
      for (int k = 1; k < STAGES; k++) begin
         if (load[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
               y_d[k]   = y_q[k-1];
               tag_d[k] = tag_q[k-1];
               ill_d[k] = ill_q[k-1];
            end
         end
      end
   end

   // Stage registers; reset drops every in-flight op and zeroes the data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k]   <= 1'b0;
            y_q[k]   <= '0;
            tag_q[k] <= '0;
            ill_q[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k]   <= v_d[k];
            y_q[k]   <= y_d[k];
            tag_q[k] <= tag_d[k];
            ill_q[k] <= ill_d[k];
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign y         = y_q[STAGES-1];
   assign tag_out   = tag_q[STAGES-1];
   assign illegal   = ill_q[STAGES-1];

endmodule
